clk_gate_ctrl_auto: RTL and testbench
=====================================

Name: clk_gate_ctrl_auto

Overview:
Parametrised successor to the fixed six-channel core clock-gating control. It drives NUM_CH gated clocks. Each channel has its own wake/drain state machine: a consumer requests its clock, waits for a ready handshake after a programmable wake latency, and the clock shuts off automatically after a programmable idle threshold. Software force-on and a global gating bypass are also provided. Sits between the core controller (weights SRAM, psum SRAM, MAC array, L0, OFIFO, SFU requesters) and the clock tree.

Parameters:
NUM_CH, 6, number of independently gated clock channels
IDLE_CNT_W, 4, width of idle threshold and drain counter
WAKE_LAT, 2, cycles from entering WAKE to ready; range 0..15

Ports:
clk  input  1  free-running core clock
reset  input  1  asynchronous, active-low reset
gating_en  input  1  1 = auto gating active; 0 = every channel's enable forced high
idle_thresh  input  IDLE_CNT_W  idle cycles kept on after a request drops; shared by all channels
req  input  NUM_CH  per-channel clock request from the consumer
force_on  input  NUM_CH  per-channel software override; enable forced high
ready  output  NUM_CH  per-channel: gated clock stable, consumer may proceed
gclk  output  NUM_CH  per-channel gated clock
gated  output  NUM_CH  per-channel status: 1 when the channel enable is low

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - every channel goes to state OFF, drain counter 0, wake counter 0
  - ready=0, gated=all 1, gclk held low
  - Mid-operation reset aborts WAKE/ON/DRAIN immediately.
- Per-channel FSM states OFF, WAKE, ON, DRAIN. Inputs are sampled on the clk rising edge.
  - OFF: req=1 -> WAKE with wake counter 0. If WAKE_LAT=0, go directly to ON.
  - WAKE: wake counter increments each cycle; at WAKE_LAT-1 -> ON. WAKE always completes even if req drops, so there are no short enable pulses.
  - ON: req=0 -> DRAIN with drain counter 0. If idle_thresh=0, go directly to OFF.
  - DRAIN: req=1 -> ON (counter cleared). Otherwise the counter increments; when counter==idle_thresh-1 -> OFF.
- Resulting clock-on time after req falls in ON: exactly idle_thresh cycles of DRAIN.
- Channel enable:
  - en[ch] = (state!=OFF) | force_on[ch] | ~gating_en
  - en is decoded only from registered state and the two inputs; no counter bits feed it.
- gclk[ch] comes from the existing clkgate latch cell: .clk(clk), .en(en[ch]). The cell's reset is active-high, so it is driven by ~reset.
- gated[ch] = ~en[ch] (combinational).
- ready[ch] = (state==ON), registered.
  - Latency with WAKE_LAT=L and req rising at edge t: state WAKE from t; ready high after edge t+L.
  - With L=0: ON and ready after edge t.
- force_on or gating_en=0 does not alter FSM sequencing or ready. The handshake is unchanged; only the enable is overridden.
- Simultaneous events:
  - req=1 at the same edge DRAIN would expire -> ON (req wins).
  - idle_thresh changing during DRAIN takes effect on the next comparison. If the counter is already >= the new threshold -> OFF next edge (compare uses >=).
- Counters saturate; they never wrap. Channels are fully independent.

Decomposition:
- Shared package clk_gate_pkg holds:
  - state enum (OFF=2'd0, WAKE=2'd1, ON=2'd2, DRAIN=2'd3)
  - default parameter constants
  - wake counter width, computed as $clog2(WAKE_LAT+1), minimum 1
- One sub-module, clk_gate_chan: one channel's FSM, both counters, the ready register and the clkgate instance. Top-level is a generate loop over NUM_CH plus the gating_en/force_on fan-out.

Test Plan:
- Reset and idle: reset low 3 cycles then high, req=0 -> ready=0, gated=all 1, gclk flat low for 20 cycles.
- Wake handshake: WAKE_LAT=2, ch0 req 0->1 at edge 10 -> gclk[0] toggles from cycle 10; ready[0] rises after edge 12; other channels stay gated.
- Drain: idle_thresh=4, ch2 in ON, req drops at edge 30 -> gclk[2] runs through edge 34; gated[2]=1 after edge 34. Repeat with idle_thresh=0 -> OFF after edge 30.
- Re-request in drain: idle_thresh=4, req drops at edge 30 and returns at edge 32 -> state ON, ready[2] back to 1 after edge 32, clock never stops.
- Overrides: gating_en=0 -> all gated=0 with req=0, ready stays 0. force_on[5]=1 -> gclk[5] runs while ch5 is OFF.
- Async reset mid-wake: reset pulled low between edges during WAKE -> gated=1 and gclk low immediately, no glitch. After release, req=1 restarts the full WAKE_LAT sequence.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and defaults for the per-channel clock-gating controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAKE  = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_NUM_CH     = 6;
  localparam int DEF_IDLE_CNT_W = 4;
  localparam int DEF_WAKE_LAT   = 2;

  function automatic int wake_cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/clk_gate_chan.sv
// One gated clock channel: wake/drain FSM, its counters, the ready flag and the gate cell.
//
// state | meaning
// OFF   | clock gated, waiting for req
// WAKE  | clock running, counting out the wake latency
// ON    | clock running, ready asserted
// DRAIN | req dropped, clock kept on for idle_thresh cycles
module clk_gate_chan
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CNT_W = DEF_IDLE_CNT_W,
  parameter int WAKE_LAT   = DEF_WAKE_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  force_on,
  input  logic                  bypass,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  output logic                  ready,
  output logic                  gclk,
  output logic                  gated
);

  localparam int WCW = wake_cnt_w(WAKE_LAT);
  localparam logic [WCW-1:0] WAKE_LAST = (WAKE_LAT > 0) ? WCW'(WAKE_LAT - 1) : '0;
  localparam logic [WCW-1:0] WAKE_ONE = WCW'(1);
  localparam logic [IDLE_CNT_W-1:0] DRAIN_ONE = IDLE_CNT_W'(1);
  localparam logic [IDLE_CNT_W:0] CMP_ONE = (IDLE_CNT_W + 1)'(1);

  state_t                state;
  logic [WCW-1:0]        wake_cnt;
  logic [IDLE_CNT_W-1:0] drain_cnt;
  logic                  drain_done;
  logic                  en;

  // >= rather than == so a threshold lowered mid-drain still terminates
  assign drain_done = ({1'b0, drain_cnt} + CMP_ONE) >= {1'b0, idle_thresh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OFF;
      wake_cnt  <= '0;
      drain_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (req) begin
            wake_cnt <= '0;
            if (WAKE_LAT == 0) begin
              state <= ON;
              ready <= 1'b1;
            end else begin
              state <= WAKE;
            end
          end
        end
        WAKE: begin
          if (wake_cnt >= WAKE_LAST) begin
            state <= ON;
            ready <= 1'b1;
          end else if (wake_cnt != '1) begin
            wake_cnt <= wake_cnt + WAKE_ONE;
          end
        end
        ON: begin
          if (!req) begin
            drain_cnt <= '0;
            ready     <= 1'b0;
            state     <= (idle_thresh == '0) ? OFF : DRAIN;
          end
        end
        DRAIN: begin
          if (req) begin
            state     <= ON;
            ready     <= 1'b1;
            drain_cnt <= '0;
          end else if (drain_done) begin
            state <= OFF;
          end else if (drain_cnt != '1) begin
            drain_cnt <= drain_cnt + DRAIN_ONE;
          end
        end
        default: begin
          state <= OFF;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign en    = (state != OFF) | force_on | bypass;
  assign gated = ~en;

  clkgate u_clkgate (
    .clk  (clk),
    .en   (en),
    .rst  (~rst_n),
    .gclk (gclk)
  );

endmodule

// File: rtl/clkgate.sv
// Latch-based clock gate: enable captured while clk is low, so gclk never glitches.
module clkgate (
  input  logic clk,
  input  logic en,
  input  logic rst,
  output logic gclk
);

  logic en_l;

  always_latch begin
    if (rst)
      en_l <= 1'b0;
    else if (!clk)
      en_l <= en;
  end

  assign gclk = clk & en_l;

endmodule

// File: rtl/clk_gate_ctrl_auto.sv
// Top of the NUM_CH-channel auto clock-gating controller; fans shared controls out to each channel.
module clk_gate_ctrl_auto
  import clk_gate_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int IDLE_CNT_W = DEF_IDLE_CNT_W,
  parameter int WAKE_LAT   = DEF_WAKE_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gating_en,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH-1:0]     force_on,
  output logic [NUM_CH-1:0]     ready,
  output logic [NUM_CH-1:0]     gclk,
  output logic [NUM_CH-1:0]     gated
);

  logic bypass;

  assign bypass = ~gating_en;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    clk_gate_chan #(
      .IDLE_CNT_W (IDLE_CNT_W),
      .WAKE_LAT   (WAKE_LAT)
    ) u_chan (
      .clk         (clk),
      .rst_n       (reset),
      .req         (req[ch]),
      .force_on    (force_on[ch]),
      .bypass      (bypass),
      .idle_thresh (idle_thresh),
      .ready       (ready[ch]),
      .gclk        (gclk[ch]),
      .gated       (gated[ch])
    );
  end

endmodule

// File: tb/tb_clk_gate_ctrl_auto.sv
// Scoreboard bench for clk_gate_ctrl_auto: stimulus queues expected outputs, a monitor checks them.
module tb_clk_gate_ctrl_auto;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       gating_en = 1'b1;
  logic [3:0] idle_thresh = 4'd4;
  logic [5:0] req = '0;
  logic [5:0] force_on = '0;
  logic [5:0] ready, gclk, gated;

  logic       n_rst = 1'b0;
  logic       n_gen = 1'b1;
  logic [3:0] n_thr = 4'd4;
  logic [5:0] n_req = '0;
  logic [5:0] n_force = '0;

  int edge_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cyc;
    logic [5:0] rdy;
    logic [5:0] gtd;
    logic [5:0] gck;
    string      nm;
  } exp_t;

  exp_t sb[$];

  clk_gate_ctrl_auto dut (
    .clk         (clk),
    .reset       (reset),
    .gating_en   (gating_en),
    .idle_thresh (idle_thresh),
    .req         (req),
    .force_on    (force_on),
    .ready       (ready),
    .gclk        (gclk),
    .gated       (gated)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %h expected %h (edge %0d)", nm, fld, act, exp, edge_cnt);
    end
  endtask

  // inputs change at the falling edge; expectation applies after the next rising edge
  task automatic step(input logic chk, input logic [5:0] er, input logic [5:0] eg,
                      input logic [5:0] ek, input string nm);
    exp_t e;
    @(negedge clk);
    reset       = n_rst;
    gating_en   = n_gen;
    idle_thresh = n_thr;
    req         = n_req;
    force_on    = n_force;
    if (chk) begin
      e.cyc = edge_cnt + 1;
      e.rdy = er;
      e.gtd = eg;
      e.gck = ek;
      e.nm  = nm;
      sb.push_back(e);
    end
  endtask

  task automatic chan_up2;
    n_req = 6'h05;
    step(1'b1, 6'h01, 6'h3A, 6'h01, "ch2_wake");
    step(1'b1, 6'h01, 6'h3A, 6'h05, "ch2_wake1");
    step(1'b1, 6'h05, 6'h3A, 6'h05, "ch2_rdy");
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(posedge clk);
      edge_cnt++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
        e = sb.pop_front();
        if (e.cyc < edge_cnt) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s: expectation for edge %0d never sampled", e.nm, e.cyc);
        end else begin
          cmp(e.nm, "ready", ready, e.rdy);
          cmp(e.nm, "gated", gated, e.gtd);
          cmp(e.nm, "gclk", gclk, e.gck);
        end
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 3; i++) step(1'b1, 6'h00, 6'h3F, 6'h00, "rst_hold");
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, 6'h00, 6'h3F, 6'h00, "idle");

    n_req = 6'h01;
    step(1'b1, 6'h00, 6'h3E, 6'h00, "wake_t");
    step(1'b1, 6'h00, 6'h3E, 6'h01, "wake_t1");
    step(1'b1, 6'h01, 6'h3E, 6'h01, "wake_rdy");

    chan_up2();
    n_req = 6'h01;
    for (int i = 0; i < 4; i++) step(1'b1, 6'h01, 6'h3A, 6'h05, "drain");
    step(1'b1, 6'h01, 6'h3E, 6'h05, "drain_off");
    step(1'b1, 6'h01, 6'h3E, 6'h01, "drain_gclk_off");

    chan_up2();
    n_req = 6'h01;
    n_thr = 4'd0;
    step(1'b1, 6'h01, 6'h3E, 6'h05, "thr0_off");
    step(1'b1, 6'h01, 6'h3E, 6'h01, "thr0_gclk_off");
    n_thr = 4'd4;

    chan_up2();
    n_req = 6'h01;
    step(1'b1, 6'h01, 6'h3A, 6'h05, "redrain0");
    step(1'b1, 6'h01, 6'h3A, 6'h05, "redrain1");
    n_req = 6'h05;
    step(1'b1, 6'h05, 6'h3A, 6'h05, "rereq_on");
    step(1'b1, 6'h05, 6'h3A, 6'h05, "rereq_hold");

    n_req = 6'h01;
    for (int i = 0; i < 3; i++) step(1'b1, 6'h01, 6'h3A, 6'h05, "shrink_drain");
    n_thr = 4'd2;
    step(1'b1, 6'h01, 6'h3E, 6'h05, "thr_shrink_off");
    n_thr = 4'd4;
    step(1'b1, 6'h01, 6'h3E, 6'h01, "thr_shrink_gclk");

    n_req = 6'h09;
    step(1'b1, 6'h01, 6'h36, 6'h01, "pulse_wake");
    n_req = 6'h01;
    step(1'b1, 6'h01, 6'h36, 6'h09, "pulse_wake1");
    step(1'b1, 6'h09, 6'h36, 6'h09, "wake_completes");
    step(1'b1, 6'h01, 6'h36, 6'h09, "ch3_drain");
    for (int i = 0; i < 3; i++) step(1'b0, 6'h00, 6'h00, 6'h00, "");
    step(1'b1, 6'h01, 6'h3E, 6'h09, "ch3_off");

    n_req = 6'h00;
    step(1'b1, 6'h00, 6'h3E, 6'h01, "ch0_drain");
    for (int i = 0; i < 3; i++) step(1'b0, 6'h00, 6'h00, 6'h00, "");
    step(1'b1, 6'h00, 6'h3F, 6'h01, "ch0_off");
    step(1'b1, 6'h00, 6'h3F, 6'h00, "all_off");

    n_gen = 1'b0;
    step(1'b1, 6'h00, 6'h00, 6'h3F, "bypass");
    step(1'b1, 6'h00, 6'h00, 6'h3F, "bypass_hold");
    n_gen = 1'b1;
    n_force = 6'h20;
    step(1'b1, 6'h00, 6'h1F, 6'h20, "force5");
    step(1'b1, 6'h00, 6'h1F, 6'h20, "force5_hold");
    n_force = 6'h00;
    step(1'b1, 6'h00, 6'h3F, 6'h00, "force_clear");

    n_req = 6'h02;
    step(1'b1, 6'h00, 6'h3D, 6'h00, "mid_wake0");
    step(1'b1, 6'h00, 6'h3D, 6'h02, "mid_wake1");
    @(posedge clk);
    #3;
    reset = 1'b0;
    n_rst = 1'b0;
    #1;
    cmp("async_rst", "ready", ready, 6'h00);
    cmp("async_rst", "gated", gated, 6'h3F);
    cmp("async_rst", "gclk", gclk, 6'h00);
    step(1'b1, 6'h00, 6'h3F, 6'h00, "rst_held");
    n_rst = 1'b1;
    step(1'b1, 6'h00, 6'h3D, 6'h00, "restart_w0");
    step(1'b1, 6'h00, 6'h3D, 6'h02, "restart_w1");
    step(1'b1, 6'h02, 6'h3D, 6'h02, "restart_rdy");

    n_req = 6'h00;
    for (int i = 0; i < 3; i++) step(1'b0, 6'h00, 6'h00, 6'h00, "");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_queue: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
